io_mailbox_responder: RTL and testbench
=======================================

// Module: io_mailbox_responder
// PURPOSE
//  - Memory-mapped I/O responder for the processor core's request/ack port (in_*/out_* side).
//  - Serves core reads from an RX FIFO filled by an external stream, and core writes into a TX FIFO drained by an external stream.
//  - Sits beside io_devices on the same read/write req/ack bus, selected by the upper address decode in top.
// PARAMETERS
//  D_WIDTH   34  data word width, both bus and streams
//  PA_WIDTH  4   I/O address width
//  DEPTH     8   entries per FIFO; power of 2, >= 2
// PORTS
//  clk           in   1         system clock, all logic rising-edge
//  reset_i       in   1         asynchronous, active-low reset
//  read_req_i    in   1         core read request, held until read_ack_o seen
//  read_addr_i   in   PA_WIDTH  read register address, stable while read_req_i high
//  dout_o        out  D_WIDTH   read data, valid in the read_ack_o cycle
//  read_ack_o    out  1         one-cycle read completion pulse
//  write_req_i   in   1         core write request, held until write_ack_o seen
//  write_addr_i  in   PA_WIDTH  write register address
//  din_i         in   D_WIDTH   write data, stable while write_req_i high
//  write_ack_o   out  1         one-cycle write completion pulse
//  rx_valid_i    in   1         external word offered to RX FIFO
//  rx_data_i     in   D_WIDTH   external RX word
//  rx_ready_o    out  1         RX FIFO accepts; = !rx_full (registered state)
//  tx_valid_o    out  1         TX FIFO head valid; = !tx_empty
//  tx_data_o     out  D_WIDTH   TX FIFO head word
//  tx_ready_i    in   1         external sink consumes head when valid&ready
// BEHAVIOUR
//  - Reset (reset_i=0, any time): FIFOs emptied, pointers/counts 0, both FSMs to IDLE, control reg 0;
//    dout_o=0, read_ack_o=0, write_ack_o=0, rx_ready_o=1, tx_valid_o=0, tx_data_o=0. A transaction cut by reset is dropped, never acked.
//  - Address map: 0 DATA (rd pops RX, wr pushes TX); 1 STATUS (rd only);
//    2 CONTROL (wr: bit0 flush RX, bit1 flush TX, self-clearing; rd returns control bits); others: rd 0, wr ignored, both still acked.
//  - STATUS word, zero-extended: [0] rx_empty [1] rx_full [2] tx_empty [3] tx_full, then rx_count and tx_count, each $clog2(DEPTH)+1 bits, rx_count lowest.
//  - Read FSM: R_IDLE -> R_ACK -> R_WAIT -> R_IDLE.
//    R_IDLE: read_req_i=1 and (addr!=0 or !rx_empty) -> capture dout_o, pop if addr 0, go R_ACK.
//    read of DATA with rx_empty: stay R_IDLE, no ack (blocking) until a word arrives.
//    R_ACK: read_ack_o=1 for exactly this cycle. R_WAIT: hold until read_req_i=0, then R_IDLE.
//    Latency: ack 1 cycle after accepting edge; no second service of one held request.
//  - Write FSM identical (W_IDLE/W_ACK/W_WAIT); DATA write with tx_full blocks in W_IDLE until space frees.
//  - dout_o holds its last value outside R_ACK.
//  - RX: same-cycle external push and core pop both occur; count unchanged. Push when full impossible (ready low).
//    Same rule for TX with core push and sink pop.
//  - Flush takes effect in the W_ACK cycle; it beats any same-cycle push/pop on that FIFO (pushed word discarded).
//  - Pointers wrap modulo DEPTH; count range 0..DEPTH inclusive.
//  - Read and write FSMs are independent; both may ack in the same cycle.
// CONFIGURATION
//  IO_MBOX_LOOPBACK_EN defined:
//    CONTROL bit2 = loopback; when 1, TX head moves to RX at 1 word/cycle whenever !tx_empty and !rx_full.
//    While looping back: tx_valid_o=0, rx_ready_o=0. Bit2 is readable at address 2.
//  IO_MBOX_LOOPBACK_EN undefined: bit2 is ignored on write and reads 0; no loopback path in the netlist.
// TESTING
//  - Reset released: STATUS read -> dout_o=0x005 (rx_empty, tx_empty, counts 0). Every output matches its reset value.
//  - Push 3 words (0x1,0x2,0x3) on rx_*; 3 DATA reads -> 0x1,0x2,0x3 in order. Each ack is 1 cycle after accept, exactly one ack per req.
//  - DATA read on empty RX: no ack for 10 cycles; rx push 0x2AAAAAAAA -> ack next cycle with that value.
//  - 8 writes with tx_ready_i=0: tx_full=1, 9th write not acked. Raise tx_ready_i for one cycle -> 9th acked; tx_data_o order preserved.
//  - Write CONTROL=0x1 while rx_valid_i=1 and RX holds 5 words -> rx_count=0 after ack; unmapped addr 7 read -> 0, acked.
//  - With IO_MBOX_LOOPBACK_EN: CONTROL=0x4, write 0x5 to DATA -> DATA read returns 0x5, tx_valid_o stays 0.
//    Assert reset_i mid-R_ACK -> read_ack_o drops immediately.

Source files
------------

// File: rtl/io_mailbox_responder.sv
// -----------------------------------------------------------------------------
// io_mailbox_responder
//
// Memory-mapped mailbox on the core's read/write req/ack I/O bus.
//  - Core DATA reads pop an RX FIFO that an external stream fills.
//  - Core DATA writes push a TX FIFO that an external sink drains.
//
// Register map (PA_WIDTH-bit address):
//   0 DATA    rd: pop RX (blocks while RX empty)
//             wr: push TX (blocks while TX full)
//   1 STATUS  rd only; zero-extended
//             {tx_count, rx_count, tx_full, tx_empty, rx_full, rx_empty}
//   2 CONTROL wr: bit0 flush RX, bit1 flush TX (self-clearing)
//             rd: returns current control bits
//   others    rd returns 0, wr ignored; both still acked
//
// Ports:
//   clk, reset_i (asynchronous, active-low)
//   read_req_i / read_addr_i / dout_o / read_ack_o        core read port
//   write_req_i / write_addr_i / din_i / write_ack_o      core write port
//   rx_valid_i / rx_data_i / rx_ready_o                   RX stream in
//   tx_valid_o / tx_data_o / tx_ready_i                   TX stream out
//   read_state / write_state                              debug: FSM state
//
// Handshakes:
//   - Streams: a word moves on a rising edge where valid and ready are both
//     high. Valid never depends on ready.
//   - Core bus: a request is held until its one-cycle ack pulse. The FSM then
//     waits for the request to drop, so one held request is served once.
//
// Optional build macro IO_MBOX_LOOPBACK_EN:
//   - CONTROL bit2 enables loopback. The TX head then moves into RX at one
//     word per cycle.
//   - While loopback is enabled, tx_valid_o and rx_ready_o are held low.
//   - When the macro is undefined, bit2 reads 0 and no loopback logic exists.
// -----------------------------------------------------------------------------
module io_mailbox_responder #(
  parameter int D_WIDTH  = 34,
  parameter int PA_WIDTH = 4,
  parameter int DEPTH    = 8
) (
  input  logic                clk,
  input  logic                reset_i,
  input  logic                read_req_i,
  input  logic [PA_WIDTH-1:0] read_addr_i,
  output logic [D_WIDTH-1:0]  dout_o,
  output logic                read_ack_o,
  input  logic                write_req_i,
  input  logic [PA_WIDTH-1:0] write_addr_i,
  input  logic [D_WIDTH-1:0]  din_i,
  output logic                write_ack_o,
  input  logic                rx_valid_i,
  input  logic [D_WIDTH-1:0]  rx_data_i,
  output logic                rx_ready_o,
  output logic                tx_valid_o,
  output logic [D_WIDTH-1:0]  tx_data_o,
  input  logic                tx_ready_i,
  output logic [1:0]          read_state,
  output logic [1:0]          write_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ACK = 2'd1, R_WAIT = 2'd2} rd_state_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_ACK = 2'd1, W_WAIT = 2'd2} wr_state_t;

  rd_state_t rd_state;
  wr_state_t wr_state;

  logic [D_WIDTH-1:0] rx_mem [DEPTH];
  logic [D_WIDTH-1:0] tx_mem [DEPTH];
  logic [AW-1:0]      rx_wptr, rx_rptr, tx_wptr, tx_rptr;
  logic [CW-1:0]      rx_count, tx_count;

  logic               rx_empty, rx_full, tx_empty, tx_full;
  logic               flush_rx, flush_tx, lb_on, lb_move;
  logic               rd_accept, wr_accept, rx_pop, rx_push, tx_pop, tx_push;
  logic [D_WIDTH-1:0] rx_push_data, rd_data;

  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count == CW'(DEPTH));
  assign tx_empty = (tx_count == '0);
  assign tx_full  = (tx_count == CW'(DEPTH));

`ifdef IO_MBOX_LOOPBACK_EN
  logic lb_q;
  assign lb_on   = lb_q;
  // Suppressed during a flush cycle so a flushed word cannot escape.
  assign lb_move = lb_on && !tx_empty && !rx_full && !flush_rx && !flush_tx;
`else
  assign lb_on   = 1'b0;
  assign lb_move = 1'b0;
`endif

  assign rx_ready_o = !rx_full && !lb_on;
  assign tx_valid_o = !tx_empty && !lb_on;
  // Gated so the output is 0 whenever no word is held, not a stale entry.
  assign tx_data_o  = tx_empty ? '0 : tx_mem[tx_rptr];

  // A DATA access is accepted only when the FIFO can serve it.
  // Any other address is served immediately.
  assign rd_accept = (rd_state == R_IDLE) && read_req_i &&
                     ((read_addr_i != '0) || !rx_empty);
  assign wr_accept = (wr_state == W_IDLE) && write_req_i &&
                     ((write_addr_i != '0) || !tx_full);

  assign rx_pop       = rd_accept && (read_addr_i == '0);
  assign tx_push      = wr_accept && (write_addr_i == '0);
  assign rx_push      = (rx_valid_i && rx_ready_o) || lb_move;
  assign rx_push_data = lb_move ? tx_mem[tx_rptr] : rx_data_i;
  assign tx_pop       = (tx_valid_o && tx_ready_i) || lb_move;

  always_comb begin
    rd_data = '0;
    case (read_addr_i)
      PA_WIDTH'(0): rd_data = rx_mem[rx_rptr];
      PA_WIDTH'(1): rd_data = D_WIDTH'({tx_count, rx_count, tx_full, tx_empty,
                                        rx_full, rx_empty});
      PA_WIDTH'(2): rd_data = D_WIDTH'({lb_on, flush_tx, flush_rx});
      default:      rd_data = '0;
    endcase
  end

  // Read FSM. The ack is registered, so it is high in the cycle after the
  // accepting edge.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      rd_state   <= R_IDLE;
      read_ack_o <= 1'b0;
      dout_o     <= '0;
    end else begin
      read_ack_o <= 1'b0;
      case (rd_state)
        R_IDLE: if (rd_accept) begin
          dout_o     <= rd_data;
          read_ack_o <= 1'b1;
          rd_state   <= R_ACK;
        end
        R_ACK:  rd_state <= R_WAIT;
        R_WAIT: if (!read_req_i) rd_state <= R_IDLE;
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  // Write FSM. The flush bits are captured at the accepting edge, so they
  // are high only during the W_ACK cycle.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      wr_state    <= W_IDLE;
      write_ack_o <= 1'b0;
      flush_rx    <= 1'b0;
      flush_tx    <= 1'b0;
`ifdef IO_MBOX_LOOPBACK_EN
      lb_q        <= 1'b0;
`endif
    end else begin
      write_ack_o <= 1'b0;
      flush_rx    <= 1'b0;
      flush_tx    <= 1'b0;
      case (wr_state)
        W_IDLE: if (wr_accept) begin
          write_ack_o <= 1'b1;
          wr_state    <= W_ACK;
          if (write_addr_i == PA_WIDTH'(2)) begin
            flush_rx <= din_i[0];
            flush_tx <= din_i[1];
`ifdef IO_MBOX_LOOPBACK_EN
            lb_q     <= din_i[2];
`endif
          end
        end
        W_ACK:  wr_state <= W_WAIT;
        W_WAIT: if (!write_req_i) wr_state <= W_IDLE;
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // RX FIFO pointers and count. A flush beats any same-cycle push or pop.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else if (flush_rx) begin
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + AW'(1);
      if (rx_pop)  rx_rptr <= rx_rptr + AW'(1);
      if (rx_push && !rx_pop)      rx_count <= rx_count + CW'(1);
      else if (!rx_push && rx_pop) rx_count <= rx_count - CW'(1);
    end
  end

  // TX FIFO pointers and count. A flush beats any same-cycle push or pop.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_count <= '0;
    end else if (flush_tx) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + AW'(1);
      if (tx_pop)  tx_rptr <= tx_rptr + AW'(1);
      if (tx_push && !tx_pop)      tx_count <= tx_count + CW'(1);
      else if (!tx_push && tx_pop) tx_count <= tx_count - CW'(1);
    end
  end

  // Storage arrays carry no reset; the pointers and counts define validity.
  always_ff @(posedge clk) begin
    if (rx_push && !flush_rx) rx_mem[rx_wptr] <= rx_push_data;
    if (tx_push && !flush_tx) tx_mem[tx_wptr] <= din_i;
  end

  assign read_state  = rd_state;
  assign write_state = wr_state;

endmodule

// File: tb/tb_io_mailbox_responder.sv
module tb_io_mailbox_responder;
  localparam int DW = 34;
  localparam int AW = 4;

  logic          clk;
  logic          reset_i;
  logic          read_req_i;
  logic [AW-1:0] read_addr_i;
  logic [DW-1:0] dout_o;
  logic          read_ack_o;
  logic          write_req_i;
  logic [AW-1:0] write_addr_i;
  logic [DW-1:0] din_i;
  logic          write_ack_o;
  logic          rx_valid_i;
  logic [DW-1:0] rx_data_i;
  logic          rx_ready_o;
  logic          tx_valid_o;
  logic [DW-1:0] tx_data_o;
  logic          tx_ready_i;
  logic [1:0]    read_state;
  logic [1:0]    write_state;

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];

  io_mailbox_responder #(.D_WIDTH(DW), .PA_WIDTH(AW), .DEPTH(8)) dut (
    .clk(clk), .reset_i(reset_i),
    .read_req_i(read_req_i), .read_addr_i(read_addr_i), .dout_o(dout_o),
    .read_ack_o(read_ack_o),
    .write_req_i(write_req_i), .write_addr_i(write_addr_i), .din_i(din_i),
    .write_ack_o(write_ack_o),
    .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i), .rx_ready_o(rx_ready_o),
    .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i),
    .read_state(read_state), .write_state(write_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    w = {2'(($urandom_range(0, 3))), 32'($urandom)};
    return w;
  endfunction

  // ---------------- driver tasks (start and end on a falling edge) ----------------
  task automatic core_read(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                           output int lat, output bit ok, output bit dbl);
    ok = 0; dbl = 0; lat = 0; data = '0;
    read_req_i = 1'b1; read_addr_i = addr;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); lat++;
      if (read_ack_o) begin ok = 1; data = dout_o; break; end
    end
    read_req_i = 1'b0;
    @(negedge clk); if (read_ack_o) dbl = 1;
    @(negedge clk); if (read_ack_o) dbl = 1;
  endtask

  task automatic core_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            output int lat, output bit ok, output bit dbl);
    ok = 0; dbl = 0; lat = 0;
    write_req_i = 1'b1; write_addr_i = addr; din_i = data;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); lat++;
      if (write_ack_o) begin ok = 1; break; end
    end
    write_req_i = 1'b0;
    @(negedge clk); if (write_ack_o) dbl = 1;
    @(negedge clk); if (write_ack_o) dbl = 1;
  endtask

  task automatic rx_push(input logic [DW-1:0] data, output bit ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (rx_ready_o) begin ok = 1; break; end
      @(negedge clk);
    end
    if (ok) begin
      rx_valid_i = 1'b1; rx_data_i = data;
      @(negedge clk);
      rx_valid_i = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [DW-1:0] d; int lat; bit ok, dbl;
    reset_i = 1'b0;
    read_req_i = 0; read_addr_i = '0; write_req_i = 0; write_addr_i = '0; din_i = '0;
    rx_valid_i = 0; rx_data_i = '0; tx_ready_i = 0;
    repeat (3) @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({dout_o, read_ack_o, write_ack_o, rx_ready_o, tx_valid_o, tx_data_o, read_state, write_state}
        !== {34'h0, 1'b0, 1'b0, 1'b1, 1'b0, 34'h0, 2'd0, 2'd0}) begin
      failures++;
      $display("FAIL reset_outputs dout=%h rack=%b wack=%b rxrdy=%b txv=%b txd=%h rs=%0d ws=%0d",
               dout_o, read_ack_o, write_ack_o, rx_ready_o, tx_valid_o, tx_data_o, read_state, write_state);
    end
    core_read(4'd1, d, lat, ok, dbl);
    checks++;
    if (!ok || d !== 34'h005 || lat != 1 || dbl) begin
      failures++;
      $display("FAIL reset_status got=%h exp=005 ok=%0b lat=%0d dbl=%0b", d, ok, lat, dbl);
    end
  endtask

  task automatic test_rx_order();
    logic [DW-1:0] d, e; int lat; bit ok, dbl;
    for (int i = 1; i <= 3; i++) begin
      rx_push(DW'(i), ok);
      exp_q.push_back(DW'(i));
    end
    for (int i = 0; i < 3; i++) begin
      core_read(4'd0, d, lat, ok, dbl);
      e = exp_q.pop_front();
      checks++;
      if (!ok || d !== e || lat != 1 || dbl) begin
        failures++;
        $display("FAIL rx_order[%0d] got=%h exp=%h ok=%0b lat=%0d dbl=%0b", i, d, e, ok, lat, dbl);
      end
    end
  endtask

  task automatic test_read_block();
    int acks = 0; int lat = 0; bit ok = 0; logic [DW-1:0] d = '0, e;
    read_req_i = 1'b1; read_addr_i = 4'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); if (read_ack_o) acks++;
    end
    checks++;
    if (acks != 0) begin
      failures++; $display("FAIL read_block_noack acks=%0d exp=0", acks);
    end
    rx_valid_i = 1'b1; rx_data_i = 34'h2AAAAAAAA;
    exp_q.push_back(34'h2AAAAAAAA);
    @(negedge clk);
    rx_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); lat++;
      if (read_ack_o) begin ok = 1; d = dout_o; break; end
    end
    read_req_i = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (!ok || d !== e || lat != 1) begin
      failures++; $display("FAIL read_block_data got=%h exp=%h ok=%0b lat=%0d", d, e, ok, lat);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_tx_full();
    logic [DW-1:0] d, w, e; int lat, acks, n; bit ok, dbl;
    tx_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      w = rand_word();
      exp_q.push_back(w);
      core_write(4'd0, w, lat, ok, dbl);
      checks++;
      if (!ok || lat != 1 || dbl) begin
        failures++; $display("FAIL tx_fill[%0d] ok=%0b lat=%0d dbl=%0b", i, ok, lat, dbl);
      end
    end
    core_read(4'd1, d, lat, ok, dbl);
    checks++;
    if (!ok || d !== 34'h809) begin
      failures++; $display("FAIL tx_full_status got=%h exp=809", d);
    end
    w = rand_word();
    exp_q.push_back(w);
    write_req_i = 1'b1; write_addr_i = 4'd0; din_i = w;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); if (write_ack_o) acks++;
    end
    checks++;
    if (acks != 0) begin
      failures++; $display("FAIL tx_full_block acks=%0d exp=0", acks);
    end
    // one sink cycle frees a slot for the blocked write
    e = exp_q.pop_front();
    checks++;
    if (tx_valid_o !== 1'b1 || tx_data_o !== e) begin
      failures++; $display("FAIL tx_head0 got=%h v=%b exp=%h", tx_data_o, tx_valid_o, e);
    end
    tx_ready_i = 1'b1;
    @(negedge clk);
    tx_ready_i = 1'b0;
    ok = 0;
    for (int i = 0; i < 5; i++) begin
      if (write_ack_o) begin ok = 1; break; end
      @(negedge clk);
    end
    write_req_i = 1'b0;
    checks++;
    if (!ok) begin
      failures++; $display("FAIL tx_ninth_ack got=0 exp=1");
    end
    repeat (2) @(negedge clk);
    n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      n++;
      if (tx_valid_o) begin
        e = exp_q.pop_front();
        checks++;
        if (tx_data_o !== e) begin
          failures++; $display("FAIL tx_drain got=%h exp=%h", tx_data_o, e);
        end
        tx_ready_i = 1'b1;
      end else tx_ready_i = 1'b0;
      @(negedge clk);
    end
    tx_ready_i = 1'b0;
    checks++;
    if (exp_q.size() != 0 || tx_valid_o !== 1'b0) begin
      failures++; $display("FAIL tx_drain_end left=%0d txv=%b exp 0/0", exp_q.size(), tx_valid_o);
    end
    exp_q.delete();
  endtask

  task automatic test_flush_unmapped();
    logic [DW-1:0] d; int lat; bit ok, dbl;
    for (int i = 0; i < 5; i++) rx_push(rand_word(), ok);
    rx_valid_i = 1'b1; rx_data_i = rand_word();
    write_req_i = 1'b1; write_addr_i = 4'd2; din_i = 34'h1;
    ok = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (write_ack_o) begin ok = 1; break; end
    end
    rx_valid_i = 1'b0; write_req_i = 1'b0;
    repeat (2) @(negedge clk);
    core_read(4'd1, d, lat, ok, dbl);
    checks++;
    if (!ok || d !== 34'h005) begin
      failures++; $display("FAIL flush_rx_status got=%h exp=005", d);
    end
    core_read(4'd2, d, lat, ok, dbl);
    checks++;
    if (!ok || d !== 34'h0) begin
      failures++; $display("FAIL control_selfclear got=%h exp=0", d);
    end
    core_read(4'd7, d, lat, ok, dbl);
    checks++;
    if (!ok || d !== 34'h0 || lat != 1 || dbl) begin
      failures++; $display("FAIL unmapped_read got=%h exp=0 ok=%0b lat=%0d", d, ok, lat);
    end
    core_write(4'd9, rand_word(), lat, ok, dbl);
    checks++;
    if (!ok || lat != 1 || dbl) begin
      failures++; $display("FAIL unmapped_write ok=%0b lat=%0d dbl=%0b exp 1/1/0", ok, lat, dbl);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d, e; int lat, n; bit ok, dbl;
    for (int r = 0; r < 5; r++) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        e = rand_word();
        rx_push(e, ok);
        exp_q.push_back(e);
      end
      for (int i = 0; i < n; i++) begin
        core_read(4'd0, d, lat, ok, dbl);
        e = exp_q.pop_front();
        checks++;
        if (!ok || d !== e || dbl) begin
          failures++; $display("FAIL b2b[%0d.%0d] got=%h exp=%h", r, i, d, e);
        end
      end
    end
  endtask

  task automatic test_concurrent();
    bit rack = 0, wack = 0; logic [DW-1:0] w;
    w = rand_word();
    read_req_i = 1'b1; read_addr_i = 4'd1;
    write_req_i = 1'b1; write_addr_i = 4'd0; din_i = w;
    @(negedge clk);
    rack = read_ack_o; wack = write_ack_o;
    read_req_i = 1'b0; write_req_i = 1'b0;
    checks++;
    if (!rack || !wack || dout_o !== 34'h005) begin
      failures++; $display("FAIL concurrent rack=%b wack=%b dout=%h exp 1/1/005", rack, wack, dout_o);
    end
    @(negedge clk);
    checks++;
    if (tx_valid_o !== 1'b1 || tx_data_o !== w) begin
      failures++; $display("FAIL concurrent_tx got=%h exp=%h", tx_data_o, w);
    end
    tx_ready_i = 1'b1;
    @(negedge clk);
    tx_ready_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_loopback();
    logic [DW-1:0] d; int lat, bad; bit ok, dbl;
    core_write(4'd2, 34'h4, lat, ok, dbl);
    core_read(4'd2, d, lat, ok, dbl);
`ifdef IO_MBOX_LOOPBACK_EN
    checks++;
    if (!ok || d !== 34'h4) begin
      failures++; $display("FAIL loopback_ctrl got=%h exp=4", d);
    end
    core_write(4'd0, 34'h5, lat, ok, dbl);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (tx_valid_o !== 1'b0 || rx_ready_o !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL loopback_gating bad_cycles=%0d exp=0", bad);
    end
    core_read(4'd0, d, lat, ok, dbl);
    checks++;
    if (!ok || d !== 34'h5) begin
      failures++; $display("FAIL loopback_data got=%h exp=5 ok=%0b", d, ok);
    end
    core_write(4'd2, 34'h0, lat, ok, dbl);
`else
    checks++;
    if (!ok || d !== 34'h0) begin
      failures++; $display("FAIL ctrl_bit2_ignored got=%h exp=0", d);
    end
`endif
  endtask

  task automatic test_reset_mid_ack();
    bit seen = 0;
    read_req_i = 1'b1; read_addr_i = 4'd1;
    @(negedge clk);
    seen = read_ack_o;
    reset_i = 1'b0;
    #1;
    checks++;
    if (!seen || read_ack_o !== 1'b0 || dout_o !== 34'h0) begin
      failures++; $display("FAIL reset_mid_ack seen=%b rack=%b dout=%h exp 1/0/0", seen, read_ack_o, dout_o);
    end
    read_req_i = 1'b0;
    @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    checks++;
    if (read_ack_o !== 1'b0 || read_state !== 2'd0 || rx_ready_o !== 1'b1) begin
      failures++; $display("FAIL post_reset rack=%b rs=%0d rxrdy=%b exp 0/0/1", read_ack_o, read_state, rx_ready_o);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_rx_order();
    test_read_block();
    test_tx_full();
    test_flush_unmapped();
    test_back_to_back();
    test_concurrent();
    test_loopback();
    test_reset_mid_ack();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
